// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame sequencer driving filter mode/brightness registers
// Frames are SOF(0xAA) CMD ARG CHK with CHK = CMD ^ ARG; partial frames are dropped on timeout.
module uart_cmd_ctrl #(
  parameter int          TIMEOUT_TICKS  = 1760,
  parameter int          NUM_MODES      = 8,
  parameter logic [7:0]  BRIGHT_DEFAULT = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_baud_tick,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [2:0] o_filter_mode,
  output logic [7:0] o_brightness,
  output logic       o_cfg_update,
  output logic       o_err,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam int             CW          = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0]  TMO_LAST    = CW'(TIMEOUT_TICKS - 1);
  localparam logic [8:0]     MODE_LIMIT  = 9'(NUM_MODES);
  localparam logic [7:0]     SOF         = 8'hAA;
  localparam logic [7:0]     CMD_MODE    = 8'h01;
  localparam logic [7:0]     CMD_BRIGHT  = 8'h02;
  localparam logic [7:0]     CMD_DEFAULT = 8'h03;

  typedef enum logic [2:0] {
    WAIT_SOF,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    APPLY
  } state_t;

  state_t          state;
  logic [7:0]      cmd_q;
  logic [7:0]      arg_q;
  logic [7:0]      chk_q;
  logic [CW-1:0]   tmo_cnt;

  logic            chk_ok;
  logic            arg_in_range;
  logic            accept;
  logic            in_frame;

  always_comb begin
    chk_ok       = (chk_q == (cmd_q ^ arg_q));
    arg_in_range = ({1'b0, arg_q} < MODE_LIMIT);
    in_frame     = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
    case (cmd_q)
      CMD_MODE:    accept = chk_ok && arg_in_range;
      CMD_BRIGHT:  accept = chk_ok;
      CMD_DEFAULT: accept = chk_ok;
      default:     accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_SOF;
      cmd_q         <= 8'h00;
      arg_q         <= 8'h00;
      chk_q         <= 8'h00;
      tmo_cnt       <= '0;
      o_filter_mode <= 3'd0;
      o_brightness  <= BRIGHT_DEFAULT;
      o_cfg_update  <= 1'b0;
      o_err         <= 1'b0;
      o_err_cnt     <= 8'h00;
      o_busy        <= 1'b0;
    end else begin
      o_cfg_update <= 1'b0;
      o_err        <= 1'b0;

      if (state == WAIT_SOF) begin
        tmo_cnt <= '0;
        if (i_rx_done && (i_rx_data == SOF)) begin
          state  <= GET_CMD;
          o_busy <= 1'b1;
        end
      end else if (in_frame) begin
        // A byte arriving on the terminal tick takes priority over the timeout.
        if (i_rx_done) begin
          tmo_cnt <= '0;
          case (state)
            GET_CMD: begin
              cmd_q <= i_rx_data;
              state <= GET_ARG;
            end
            GET_ARG: begin
              arg_q <= i_rx_data;
              state <= GET_CHK;
            end
            default: begin
              chk_q <= i_rx_data;
              state <= APPLY;
            end
          endcase
        end else if (i_baud_tick) begin
          if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
            state   <= WAIT_SOF;
            o_busy  <= 1'b0;
            o_err   <= 1'b1;
            if (o_err_cnt != 8'hFF) begin
              o_err_cnt <= o_err_cnt + 8'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      end else if (state == APPLY) begin
        // Bytes strobed during this cycle are dropped.
        state   <= WAIT_SOF;
        o_busy  <= 1'b0;
        tmo_cnt <= '0;
        if (accept) begin
          o_cfg_update <= 1'b1;
          case (cmd_q)
            CMD_MODE:   o_filter_mode <= arg_q[2:0];
            CMD_BRIGHT: o_brightness  <= arg_q;
            default: begin
              o_filter_mode <= 3'd0;
              o_brightness  <= BRIGHT_DEFAULT;
            end
          endcase
        end else begin
          o_err <= 1'b1;
          if (o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'd1;
          end
        end
      end else begin
        state   <= WAIT_SOF;
        o_busy  <= 1'b0;
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
// Directed scenarios plus randomized frames scored against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int         TIMEOUT_TICKS  = 1760;
  localparam int         NUM_MODES      = 8;
  localparam logic [7:0] BRIGHT_DEFAULT = 8'h80;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_baud_tick;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [2:0] o_filter_mode;
  logic [7:0] o_brightness;
  logic       o_cfg_update;
  logic       o_err;
  logic [7:0] o_err_cnt;
  logic       o_busy;

  uart_cmd_ctrl #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .NUM_MODES     (NUM_MODES),
    .BRIGHT_DEFAULT(BRIGHT_DEFAULT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_baud_tick  (i_baud_tick),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_filter_mode(o_filter_mode),
    .o_brightness (o_brightness),
    .o_cfg_update (o_cfg_update),
    .o_err        (o_err),
    .o_err_cnt    (o_err_cnt),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_pulses = 0;
  int err_pulses = 0;
  bit rand_ticks = 1'b0;

  logic [2:0] m_mode;
  logic [7:0] m_bright;
  int         m_errcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (o_cfg_update || o_err)) begin
      if (o_cfg_update) upd_pulses++;
      if (o_err) err_pulses++;
      check("upd_err_exclusive", {31'b0, o_cfg_update & o_err}, 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data   = b;
    i_rx_done   = 1'b1;
    i_baud_tick = 1'b0;
    cyc();
    i_rx_done = 1'b0;
    repeat (gap) begin
      i_baud_tick = rand_ticks ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
    end
    i_baud_tick = 1'b0;
  endtask

  // Frame-level rule: commit on a good frame, count on a bad one.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                             output bit acc);
    bit chk_good;
    chk_good = (chk == (cmd ^ arg));
    if (cmd == 8'h01)      acc = chk_good && (int'(arg) < NUM_MODES);
    else if (cmd == 8'h02) acc = chk_good;
    else if (cmd == 8'h03) acc = chk_good;
    else                   acc = 1'b0;
    if (acc) begin
      if (cmd == 8'h01) m_mode = arg[2:0];
      else if (cmd == 8'h02) m_bright = arg;
      else begin
        m_mode   = 3'd0;
        m_bright = BRIGHT_DEFAULT;
      end
    end else begin
      m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] cmd, input logic [7:0] arg,
                            input logic [7:0] chk, input bit full, input int nnoise);
    int u0, e0;
    bit acc;
    logic [7:0] nb;
    u0 = upd_pulses;
    e0 = err_pulses;
    for (int i = 0; i < nnoise; i++) begin
      nb = 8'($urandom);
      if (nb == 8'hAA) nb = 8'h55;
      send_byte(nb, 1);
    end
    send_byte(8'hAA, 1);
    send_byte(cmd, 1);
    send_byte(arg, 1);
    send_byte(chk, 1);
    repeat (3) cyc();
    model_frame(cmd, arg, chk, acc);
    if (full) begin
      check({tag, "_mode"},   32'(o_filter_mode), 32'(m_mode));
      check({tag, "_bright"}, 32'(o_brightness),  32'(m_bright));
      check({tag, "_errcnt"}, 32'(o_err_cnt),     32'(m_errcnt));
      check({tag, "_upd"},    32'(upd_pulses - u0), acc ? 32'd1 : 32'd0);
      check({tag, "_errp"},   32'(err_pulses - e0), acc ? 32'd0 : 32'd1);
      check({tag, "_busy"},   32'(o_busy), 32'd0);
    end
  endtask

  task automatic model_reset();
    m_mode   = 3'd0;
    m_bright = BRIGHT_DEFAULT;
    m_errcnt = 0;
  endtask

  initial begin
    int u0, e0;
    bit acc;
    logic [7:0] cmd, arg, chk;
    int r;

    reset       = 1'b1;
    i_baud_tick = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_done   = 1'b0;
    model_reset();
    cyc();
    cyc();
    check("rst_mode",   32'(o_filter_mode), 32'd0);
    check("rst_bright", 32'(o_brightness),  32'(BRIGHT_DEFAULT));
    check("rst_errcnt", 32'(o_err_cnt),     32'd0);
    check("rst_busy",   32'(o_busy),        32'd0);
    check("rst_upd",    32'(o_cfg_update),  32'd0);
    check("rst_err",    32'(o_err),         32'd0);
    reset = 1'b0;
    cyc();

    // 1: latency of the update strobe after the CHK byte
    u0 = upd_pulses;
    send_byte(8'hAA, 1);
    send_byte(8'h01, 1);
    send_byte(8'h03, 1);
    i_rx_data = 8'h02;
    i_rx_done = 1'b1;
    cyc();
    i_rx_done = 1'b0;
    check("t1_upd_n1", 32'(o_cfg_update), 32'd0);
    cyc();
    check("t1_upd_n2",  32'(o_cfg_update),  32'd1);
    check("t1_mode_n2", 32'(o_filter_mode), 32'd3);
    cyc();
    check("t1_upd_n3", 32'(o_cfg_update), 32'd0);
    model_frame(8'h01, 8'h03, 8'h02, acc);
    check("t1_errcnt", 32'(o_err_cnt), 32'(m_errcnt));
    check("t1_busy",   32'(o_busy), 32'd0);
    check("t1_npulse", 32'(upd_pulses - u0), 32'd1);

    // 2, 3: rejected frames
    send_frame("t2_badchk", 8'h02, 8'h40, 8'h00, 1'b1, 0);
    send_frame("t3_range",  8'h01, 8'h09, 8'h08, 1'b1, 0);
    send_frame("t3_edge",   8'h01, 8'h08, 8'h09, 1'b1, 0);
    send_frame("t3_max",    8'h01, 8'h07, 8'h06, 1'b1, 0);
    send_frame("t3_unk",    8'h99, 8'h00, 8'h99, 1'b1, 0);

    // 4: junk before SOF is silently ignored
    e0 = err_pulses;
    send_byte(8'h55, 1);
    send_byte(8'h13, 1);
    cyc();
    check("t4_noerr",  32'(err_pulses - e0), 32'd0);
    check("t4_idle",   32'(o_busy), 32'd0);
    send_frame("t4_frame", 8'h02, 8'h20, 8'h22, 1'b1, 0);

    // 5: timeout of a partial frame
    e0 = err_pulses;
    send_byte(8'hAA, 1);
    send_byte(8'h01, 1);
    repeat (TIMEOUT_TICKS - 1) begin
      i_baud_tick = 1'b1;
      cyc();
      i_baud_tick = 1'b0;
      cyc();
    end
    check("t5_pre_busy", 32'(o_busy), 32'd1);
    check("t5_pre_err",  32'(err_pulses - e0), 32'd0);
    i_baud_tick = 1'b1;
    cyc();
    i_baud_tick = 1'b0;
    m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
    check("t5_err",    32'(o_err),  32'd1);
    check("t5_busy",   32'(o_busy), 32'd0);
    cyc();
    check("t5_errcnt", 32'(o_err_cnt), 32'(m_errcnt));
    check("t5_npulse", 32'(err_pulses - e0), 32'd1);
    send_frame("t5_after", 8'h01, 8'h05, 8'h04, 1'b1, 0);

    // 5b: byte on the terminal tick wins over the timeout
    e0 = err_pulses;
    u0 = upd_pulses;
    send_byte(8'hAA, 1);
    repeat (TIMEOUT_TICKS - 1) begin
      i_baud_tick = 1'b1;
      cyc();
      i_baud_tick = 1'b0;
      cyc();
    end
    i_rx_data   = 8'h01;
    i_rx_done   = 1'b1;
    i_baud_tick = 1'b1;
    cyc();
    i_rx_done   = 1'b0;
    i_baud_tick = 1'b0;
    cyc();
    check("t5b_busy", 32'(o_busy), 32'd1);
    check("t5b_noerr", 32'(err_pulses - e0), 32'd0);
    send_byte(8'h06, 1);
    send_byte(8'h07, 1);
    repeat (3) cyc();
    model_frame(8'h01, 8'h06, 8'h07, acc);
    check("t5b_mode", 32'(o_filter_mode), 32'(m_mode));
    check("t5b_upd",  32'(upd_pulses - u0), 32'd1);
    check("t5b_errp", 32'(err_pulses - e0), 32'd0);

    // Randomized frames with noise bytes and sparse baud ticks
    rand_ticks = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0:       cmd = 8'h01;
        1:       cmd = 8'h02;
        2:       cmd = 8'h03;
        default: cmd = 8'($urandom);
      endcase
      arg = (cmd == 8'h01) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      chk = ($urandom_range(0, 3) != 0) ? (cmd ^ arg) : 8'($urandom);
      send_frame("rnd", cmd, arg, chk, 1'b1, int'($urandom_range(0, 2)));
    end
    rand_ticks = 1'b0;

    // 6: error counter saturation
    for (int n = 0; n < 300; n++) begin
      send_frame("sat", 8'h02, 8'(n), 8'(n) ^ 8'h5A, 1'b0, 0);
    end
    check("t6_sat_model", 32'(o_err_cnt), 32'(m_errcnt));
    check("t6_sat_255",   32'(o_err_cnt), 32'd255);

    // 6b: reset mid-frame
    send_byte(8'hAA, 1);
    send_byte(8'h02, 1);
    reset = 1'b1;
    #2;
    model_reset();
    check("t6_rst_mode",   32'(o_filter_mode), 32'd0);
    check("t6_rst_bright", 32'(o_brightness),  32'(BRIGHT_DEFAULT));
    check("t6_rst_errcnt", 32'(o_err_cnt),     32'd0);
    check("t6_rst_busy",   32'(o_busy),        32'd0);
    check("t6_rst_upd",    32'(o_cfg_update),  32'd0);
    check("t6_rst_err",    32'(o_err),         32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    send_frame("t6_post", 8'h03, 8'h00, 8'h03, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
